axis_pkt_gen: RTL and testbench

- AXI-Stream packet generator: the driving end of the AXI-Stream interface that our monitor blocks observe passively.
- Emits packets with a deterministic incrementing data pattern, configurable length and inter-packet gap, for a fixed packet count or continuously.
- Used in loopback/BIST paths and sim benches; its output is checked by a downstream checker or monitor.

---
 rtl/axis_pkt_gen.sv | 143 ++++++++++++++
 tb/tb_axis_pkt_gen.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: incrementing data pattern, configurable length/gap,
// fixed packet count or continuous until stopped.
module axis_pkt_gen #(
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 16,
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic [LEN_W-1:0]   cfg_gap,
   input  logic [COUNT_W-1:0] cfg_num_pkts,
   output logic [DATA_W-1:0]  o_tdata,
   output logic               o_tlast,
   output logic               o_tvalid,
   input  logic               o_tready,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] pkt_count,
   output logic [COUNT_W-1:0] xfer_count
);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);
   localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);
   localparam logic [DATA_W-1:0]  DATA_ONE  = DATA_W'(1);

   state_t               state_q;
   logic [LEN_W-1:0]     len_q, gap_q, beat_q, gap_cnt_q;
   logic [COUNT_W-1:0]   num_q, pkt_q, xfer_q;
   logic [DATA_W-1:0]    data_q;
   logic                 tlast_q, tvalid_q, busy_q, done_q, stop_pend_q;

   logic                 xfer_d;
   logic [LEN_W-1:0]     eff_len_d, beat_inc_d;
   logic [COUNT_W-1:0]   pkt_inc_d;
   logic                 run_end_d;

   assign xfer_d     = tvalid_q & o_tready;
   assign eff_len_d  = (cfg_len == '0) ? LEN_ONE : cfg_len;
   assign beat_inc_d = beat_q + LEN_ONE;
   assign pkt_inc_d  = pkt_q + COUNT_ONE;
   // A stop arriving on the final tlast beat folds into the same termination.
   assign run_end_d  = stop_pend_q | stop | ((num_q != '0) && (pkt_inc_d == num_q));

   // Run configuration is frozen at the accepted start.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && start) begin
         len_q <= eff_len_d;
         gap_q <= cfg_gap;
         num_q <= cfg_num_pkts;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         data_q      <= '0;
         beat_q      <= '0;
         gap_cnt_q   <= '0;
         pkt_q       <= '0;
         xfer_q      <= '0;
         tlast_q     <= 1'b0;
         tvalid_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         stop_pend_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q     <= SEND;
                  data_q      <= '0;
                  beat_q      <= '0;
                  pkt_q       <= '0;
                  xfer_q      <= '0;
                  tvalid_q    <= 1'b1;
                  tlast_q     <= (eff_len_d == LEN_ONE);
                  busy_q      <= 1'b1;
                  stop_pend_q <= 1'b0;
               end
            end
            SEND: begin
               if (stop) stop_pend_q <= 1'b1;
               if (xfer_d) begin
                  data_q <= data_q + DATA_ONE;
                  xfer_q <= xfer_q + COUNT_ONE;
                  if (tlast_q) begin
                     pkt_q  <= pkt_inc_d;
                     beat_q <= '0;
                     if (run_end_d) begin
                        state_q     <= IDLE;
                        tvalid_q    <= 1'b0;
                        tlast_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        stop_pend_q <= 1'b0;
                     end else if (gap_q != '0) begin
                        state_q   <= GAP;
                        tvalid_q  <= 1'b0;
                        tlast_q   <= 1'b0;
                        gap_cnt_q <= gap_q;
                     end else begin
                        tlast_q <= (len_q == LEN_ONE);
                     end
                  end else begin
                     beat_q  <= beat_inc_d;
                     tlast_q <= (beat_inc_d == len_q - LEN_ONE);
                  end
               end
            end
            GAP: begin
               if (stop) begin
                  state_q     <= IDLE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  stop_pend_q <= 1'b0;
               end else if (gap_cnt_q == LEN_ONE) begin
                  state_q  <= SEND;
                  tvalid_q <= 1'b1;
                  tlast_q  <= (len_q == LEN_ONE);
               end else begin
                  gap_cnt_q <= gap_cnt_q - LEN_ONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_tdata    = data_q;
   assign o_tlast    = tlast_q;
   assign o_tvalid   = tvalid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pkt_count  = pkt_q;
   assign xfer_count = xfer_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Scoreboard bench for axis_pkt_gen: expected beats queued per run, monitor checks
// every transfer, stall stability, gap length and done pulses.
module tb_axis_pkt_gen;
   localparam int DATA_W  = 32;
   localparam int LEN_W   = 16;
   localparam int COUNT_W = 32;

   logic               clk, rst, start, stop, o_tready;
   logic [LEN_W-1:0]   cfg_len, cfg_gap;
   logic [COUNT_W-1:0] cfg_num_pkts;
   logic [DATA_W-1:0]  o_tdata;
   logic               o_tlast, o_tvalid, busy, done;
   logic [COUNT_W-1:0] pkt_count, xfer_count;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    failures = 0;
   int    exp_gap = 0;
   int    done_cnt = 0;
   int    ready_mode = 0;

   axis_pkt_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W), .COUNT_W(COUNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_num_pkts(cfg_num_pkts),
      .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
      .busy(busy), .done(done), .pkt_count(pkt_count), .xfer_count(xfer_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Sink ready pattern: 0 always, 1 toggling, 2 random, 3 held low.
   initial begin
      o_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: o_tready = 1'b1;
            1: o_tready = ~o_tready;
            2: o_tready = 1'($urandom_range(0, 1));
            default: o_tready = 1'b0;
         endcase
      end
   end

   logic              prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;
   logic              prev_last = 1'b0;
   bit                gap_on = 1'b0;
   int                low_cnt = 0;

   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
            gap_on     = 1'b0;
         end else begin
            if (done) begin
               done_cnt++;
               gap_on = 1'b0;
            end
            if (prev_stall) begin
               check("hold_valid", longint'(o_tvalid), 1);
               check("hold_data", longint'(o_tdata), longint'(prev_data));
               check("hold_last", longint'(o_tlast), longint'(prev_last));
            end
            if (gap_on && o_tvalid) begin
               check("gap_len", low_cnt, exp_gap);
               gap_on = 1'b0;
            end else if (gap_on) begin
               low_cnt++;
            end
            if (o_tvalid && o_tready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_beat: got data=%0d last=%0b, none expected",
                           o_tdata, o_tlast);
               end else begin
                  e = exp_q.pop_front();
                  check("tdata", longint'(o_tdata), longint'(e.data));
                  check("tlast", longint'(o_tlast), longint'(e.last));
               end
               if (o_tlast) begin
                  gap_on  = 1'b1;
                  low_cnt = 0;
               end
            end
            prev_stall = o_tvalid && !o_tready;
            prev_data  = o_tdata;
            prev_last  = o_tlast;
         end
      end
   end

   // Reference: every run starts at word 0; packets are max(len,1) beats.
   task automatic push_run(input int len, input int npk);
      int    l;
      int    w;
      beat_t t;
      l = (len == 0) ? 1 : len;
      w = 0;
      for (int p = 0; p < npk; p++) begin
         for (int b = 0; b < l; b++) begin
            t.data = DATA_W'(w);
            t.last = (b == l - 1);
            exp_q.push_back(t);
            w++;
         end
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic do_run(input int len, input int gap, input int num, input int stop_k,
                         input int rmode, input bit poke);
      int l;
      int npk;
      int i;
      l   = (len == 0) ? 1 : len;
      npk = (num != 0) ? num : (stop_k / l + 1);
      ready_mode = rmode;
      exp_gap    = gap;
      done_cnt   = 0;
      push_run(len, npk);
      cfg_len      = LEN_W'(len);
      cfg_gap      = LEN_W'(gap);
      cfg_num_pkts = COUNT_W'(num);
      pulse_start();
      check("start_tvalid", longint'(o_tvalid), 1);
      check("start_busy", longint'(busy), 1);
      check("start_tdata", longint'(o_tdata), 0);
      cfg_len      = LEN_W'($urandom);
      cfg_gap      = LEN_W'($urandom);
      cfg_num_pkts = $urandom;
      if (stop_k >= 0) begin
         i = 0;
         while (xfer_count != COUNT_W'(stop_k) && i < 2000) begin
            @(posedge clk);
            #1;
            i++;
         end
         if (i >= 2000) begin
            checks++;
            failures++;
            $display("FAIL stop_wait: got xfer_count=%0d required %0d", xfer_count, stop_k);
         end
         stop = 1'b1;
         @(posedge clk);
         #1;
         stop = 1'b0;
      end
      i = 0;
      while (!done && i < 3000) begin
         start = poke && busy && ((i % 4) == 2);
         @(posedge clk);
         #1;
         start = 1'b0;
         i++;
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL done_timeout: got done=0 required 1 within 3000 cycles");
      end else begin
         check("done_busy", longint'(busy), 0);
         check("pkt_count", longint'(pkt_count), npk);
         check("xfer_count", longint'(xfer_count), npk * l);
         check("queue_empty", exp_q.size(), 0);
         @(posedge clk);
         #1;
         check("done_pulse", longint'(done), 0);
         check("done_count", done_cnt, 1);
         check("idle_tvalid", longint'(o_tvalid), 0);
         check("hold_pkt", longint'(pkt_count), npk);
      end
      exp_q.delete();
   endtask

   initial begin
      int i;
      int len, gap, num, stop_k, rmode;
      bit poke;
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      cfg_len = '0; cfg_gap = '0; cfg_num_pkts = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_tvalid", longint'(o_tvalid), 0);
      check("rst_tlast", longint'(o_tlast), 0);
      check("rst_tdata", longint'(o_tdata), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);
      check("rst_pkt", longint'(pkt_count), 0);
      check("rst_xfer", longint'(xfer_count), 0);

      do_run(4, 0, 2, -1, 0, 1'b0);
      do_run(3, 2, 3, -1, 1, 1'b1);
      do_run(5, 0, 0, 16, 0, 1'b0);
      do_run(0, 0, 3, -1, 0, 1'b0);

      // Stop while in the gap, with an ignored start just before it.
      ready_mode = 0; exp_gap = 10; done_cnt = 0;
      push_run(3, 1);
      cfg_len = 3; cfg_gap = 10; cfg_num_pkts = 0;
      pulse_start();
      i = 0;
      while (!(xfer_count == 3 && !o_tvalid) && i < 200) begin
         @(posedge clk);
         #1;
         i++;
      end
      check("gap_reached", longint'(xfer_count), 3);
      pulse_start();
      check("gap_start_busy", longint'(busy), 1);
      check("gap_start_tvalid", longint'(o_tvalid), 0);
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      check("gapstop_done", longint'(done), 1);
      check("gapstop_tvalid", longint'(o_tvalid), 0);
      check("gapstop_busy", longint'(busy), 0);
      check("gapstop_pkt", longint'(pkt_count), 1);
      check("gapstop_xfer", longint'(xfer_count), 3);
      @(posedge clk);
      #1;
      check("gapstop_done_low", longint'(done), 0);
      check("gapstop_tvalid_low", longint'(o_tvalid), 0);
      check("gapstop_done_count", done_cnt, 1);
      exp_q.delete();

      // Reset while stalled mid-packet.
      ready_mode = 3; o_tready = 1'b0;
      cfg_len = 8; cfg_gap = 0; cfg_num_pkts = 0;
      pulse_start();
      repeat (3) @(posedge clk);
      #1;
      check("stall_tvalid", longint'(o_tvalid), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_tvalid", longint'(o_tvalid), 0);
      check("midrst_busy", longint'(busy), 0);
      check("midrst_pkt", longint'(pkt_count), 0);
      check("midrst_xfer", longint'(xfer_count), 0);
      check("midrst_tdata", longint'(o_tdata), 0);
      check("midrst_done", longint'(done), 0);
      exp_q.delete();
      do_run(4, 1, 2, -1, 0, 1'b0);

      for (int r = 0; r < 10; r++) begin
         len   = $urandom_range(0, 6);
         rmode = $urandom_range(0, 2);
         poke  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) begin
            gap = 0; num = 0; stop_k = $urandom_range(0, 20);
         end else begin
            gap = $urandom_range(0, 4); num = $urandom_range(1, 4); stop_k = -1;
         end
         do_run(len, gap, num, stop_k, rmode, poke);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
